// File: rtl/flag_stack.sv
// flag_stack: condition-flag register with a save/restore LIFO.
// Holds FLAG_W selectively writable flags and a DEPTH-entry stack for
// interrupt entry/return and call/return. Optional macro FLAG_STACK_ERR_EN
// adds a sticky overflow/underflow error flag; otherwise err is tied to 0.
module flag_stack #(
  parameter int FLAG_W = 3,
  parameter int DEPTH  = 4,
  parameter int SP_W   = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [FLAG_W-1:0] flag_sel,
  input  logic [FLAG_W-1:0] flag_val,
  input  logic              push,
  input  logic              pop,
  output logic [FLAG_W-1:0] flag_out,
  output logic [SP_W-1:0]   sp,
  output logic              empty,
  output logic              full,
  output logic              err
);

  // Per-bit selective update of the current flag vector.
  function automatic logic [FLAG_W-1:0] merge_flags(
    input logic [FLAG_W-1:0] cur,
    input logic [FLAG_W-1:0] sel,
    input logic [FLAG_W-1:0] val
  );
    return (cur & ~sel) | (val & sel);
  endfunction

  logic [FLAG_W-1:0] flag_p0;
  logic [SP_W-1:0]   sp_p0;
  logic [FLAG_W-1:0] stack_p0 [DEPTH];

  logic [SP_W-1:0]   top_idx;
  logic [SP_W-1:0]   wr_idx;
  logic [FLAG_W-1:0] rd_top;
  logic [FLAG_W-1:0] flag_nxt;
  logic [SP_W-1:0]   sp_nxt;
  logic              is_empty;
  logic              is_full;
  logic              do_push;
  logic              do_pop;
  logic              do_xchg;
  logic              stk_we;

  assign is_empty = (sp_p0 == '0);
  assign is_full  = (sp_p0 == SP_W'(DEPTH));
  assign top_idx  = sp_p0 - SP_W'(1);

  // A push+pop on an empty stack degenerates into a plain push.
  assign do_xchg = push && pop && !is_empty;
  assign do_push = push && (!pop || is_empty) && !is_full;
  assign do_pop  = pop && !push && !is_empty;
  assign stk_we  = do_push || do_xchg;
  assign wr_idx  = do_xchg ? top_idx : sp_p0;

  // Combinational read of the top-of-stack entry; sp guards validity.
  always_comb begin
    rd_top = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (top_idx == SP_W'(i)) rd_top = stack_p0[i];
    end
  end

  // Next flag vector and occupancy from the {push, pop} decode.
  always_comb begin
    flag_nxt = merge_flags(flag_p0, flag_sel, flag_val);
    sp_nxt   = sp_p0;
    if (do_pop || do_xchg) flag_nxt = rd_top;
    if (do_push)           sp_nxt   = sp_p0 + SP_W'(1);
    else if (do_pop)       sp_nxt   = sp_p0 - SP_W'(1);
  end

  // Flag register and occupancy count.
  always_ff @(posedge clk) begin
    if (rst) begin
      flag_p0 <= '0;
      sp_p0   <= '0;
    end else begin
      flag_p0 <= flag_nxt;
      sp_p0   <= sp_nxt;
    end
  end

  // Stack storage is never reset; the pre-edge flag vector is saved.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (!rst && stk_we && (wr_idx == SP_W'(i))) stack_p0[i] <= flag_p0;
    end
  end

`ifdef FLAG_STACK_ERR_EN
  logic err_p0;
  logic overflow;
  logic underflow;

  assign overflow  = push && !pop && is_full;
  assign underflow = pop && !push && is_empty;

  // Sticky error, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst)                         err_p0 <= 1'b0;
    else if (overflow || underflow)  err_p0 <= 1'b1;
  end

  assign err = err_p0;
`else
  assign err = 1'b0;
`endif

  assign flag_out = flag_p0;
  assign sp       = sp_p0;
  assign empty    = is_empty;
  assign full     = is_full;

endmodule

// File: tb/tb_flag_stack.sv
// Directed self-checking bench for flag_stack: default build (3 flags,
// depth 4) and a wide/shallow instance (8 flags, depth 1).
module tb_flag_stack;

`ifdef FLAG_STACK_ERR_EN
  localparam int ERR_EN = 1;
`else
  localparam int ERR_EN = 0;
`endif

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  // Default instance
  logic       rst;
  logic [2:0] flag_sel, flag_val;
  logic       push, pop;
  logic [2:0] flag_out;
  logic [2:0] sp;
  logic       empty, full, err;

  // Wide instance
  logic       rst8;
  logic [7:0] sel8, val8;
  logic       push8, pop8;
  logic [7:0] out8;
  logic       sp8;
  logic       empty8, full8, err8;

  int n_checks = 0;
  int n_fail   = 0;

  flag_stack u_dut (
    .clk(clk), .rst(rst), .flag_sel(flag_sel), .flag_val(flag_val),
    .push(push), .pop(pop), .flag_out(flag_out), .sp(sp),
    .empty(empty), .full(full), .err(err)
  );

  flag_stack #(.FLAG_W(8), .DEPTH(1)) u_dut8 (
    .clk(clk), .rst(rst8), .flag_sel(sel8), .flag_val(val8),
    .push(push8), .pop(pop8), .flag_out(out8), .sp(sp8),
    .empty(empty8), .full(full8), .err(err8)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic p, input logic q, input logic [2:0] s, input logic [2:0] v);
    push = p; pop = q; flag_sel = s; flag_val = v;
  endtask

  initial begin
    rst = 1'b1; drive(0, 0, 3'b000, 3'b000);
    rst8 = 1'b1; sel8 = '0; val8 = '0; push8 = 0; pop8 = 0;
    step(); step();
    check("rst_flags", 32'(flag_out), 0);
    check("rst_sp", 32'(sp), 0);
    check("rst_err", 32'(err), 0);
    check("rst_empty", 32'(empty), 1);
    check("rst_full", 32'(full), 0);

    // Reset and write
    rst = 1'b0;
    drive(0, 0, 3'b101, 3'b111); step();
    check("write_partial", 32'(flag_out), 32'h5);

    // Push/pop round trip
    drive(0, 0, 3'b111, 3'b010); step();
    check("set_010", 32'(flag_out), 32'h2);
    drive(1, 0, 3'b111, 3'b001); step();
    check("rt_push_flags", 32'(flag_out), 32'h1);
    check("rt_push_sp", 32'(sp), 1);
    drive(0, 1, 3'b111, 3'b111); step();
    check("rt_pop_flags", 32'(flag_out), 32'h2);
    check("rt_pop_sp", 32'(sp), 0);
    check("rt_err", 32'(err), 0);

    // Fill and overflow: stack receives 1,2,3,4
    drive(0, 0, 3'b111, 3'b001); step();
    for (int i = 1; i <= 4; i++) begin
      drive(1, 0, 3'b111, 3'(i + 1)); step();
      check("fill_sp", 32'(sp), 32'(i));
      check("fill_flags", 32'(flag_out), 32'(i + 1));
      check("fill_full", 32'(full), (i == 4) ? 1 : 0);
    end
    check("fill_err_pre", 32'(err), 0);
    drive(1, 0, 3'b000, 3'b000); step();
    check("ovf_sp", 32'(sp), 4);
    check("ovf_flags", 32'(flag_out), 5);
    check("ovf_err", 32'(err), 32'(ERR_EN));
    for (int i = 4; i >= 1; i--) begin
      drive(0, 1, 3'b000, 3'b000); step();
      check("drain_flags", 32'(flag_out), 32'(i));
      check("drain_sp", 32'(sp), 32'(i - 1));
    end
    check("drain_empty", 32'(empty), 1);

    // Underflow
    rst = 1'b1; step(); rst = 1'b0;
    drive(0, 0, 3'b111, 3'b110); step();
    drive(0, 1, 3'b001, 3'b001); step();
    check("udf_flags", 32'(flag_out), 32'h7);
    check("udf_sp", 32'(sp), 0);
    check("udf_err", 32'(err), 32'(ERR_EN));

    // Exchange
    rst = 1'b1; step(); rst = 1'b0;
    drive(0, 0, 3'b111, 3'b110); step();
    drive(1, 0, 3'b000, 3'b000); step();
    check("xchg_push_sp", 32'(sp), 1);
    drive(0, 0, 3'b111, 3'b011); step();
    drive(1, 1, 3'b111, 3'b000); step();
    check("xchg_flags", 32'(flag_out), 32'h6);
    check("xchg_sp", 32'(sp), 1);
    check("xchg_err", 32'(err), 0);
    drive(0, 1, 3'b000, 3'b000); step();
    check("xchg_pop_flags", 32'(flag_out), 32'h3);
    check("xchg_pop_sp", 32'(sp), 0);
    // Exchange on empty acts as push
    drive(1, 1, 3'b111, 3'b101); step();
    check("xe_flags", 32'(flag_out), 32'h5);
    check("xe_sp", 32'(sp), 1);
    check("xe_err", 32'(err), 0);
    drive(0, 1, 3'b000, 3'b000); step();
    check("xe_pop_flags", 32'(flag_out), 32'h3);

    // Reset mid-stack
    drive(0, 1, 3'b000, 3'b000); step();
    check("mid_udf_err", 32'(err), 32'(ERR_EN));
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 3'b111, 3'(i)); step();
    end
    check("mid_sp3", 32'(sp), 3);
    drive(0, 0, 3'b000, 3'b000);
    rst = 1'b1; step(); rst = 1'b0;
    check("mid_rst_sp", 32'(sp), 0);
    check("mid_rst_err", 32'(err), 0);
    check("mid_rst_empty", 32'(empty), 1);
    check("mid_rst_flags", 32'(flag_out), 0);

    // Wide, single-entry instance
    check("w_rst_out", 32'(out8), 0);
    check("w_rst_sp", 32'(sp8), 0);
    rst8 = 1'b0;
    sel8 = 8'hFF; val8 = 8'hA5; step();
    check("w_write", 32'(out8), 32'hA5);
    push8 = 1; val8 = 8'h3C; step();
    check("w_push_out", 32'(out8), 32'h3C);
    check("w_push_sp", 32'(sp8), 1);
    check("w_full", 32'(full8), 1);
    sel8 = 8'h00; step();
    check("w_ovf_sp", 32'(sp8), 1);
    check("w_ovf_err", 32'(err8), 32'(ERR_EN));
    push8 = 0; pop8 = 1; step();
    check("w_pop_out", 32'(out8), 32'hA5);
    check("w_pop_sp", 32'(sp8), 0);
    check("w_empty", 32'(empty8), 1);
    pop8 = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
